// File: rtl/core_id_scoreboard_pkg.sv
// core_id_scoreboard_pkg: shared sizing constants for the decode-stage scoreboard.
package core_id_scoreboard_pkg;
    localparam int CORE_RFIDX_WIDTH = 5;
    localparam int CORE_SB_DEPTH    = 4;
endpackage

// File: rtl/core_sb_match.sv
// core_sb_match: youngest in-flight producer search for one source operand; returns hit and its done bit.
module core_sb_match
    import core_id_scoreboard_pkg::*;
#(
    parameter int DEPTH   = CORE_SB_DEPTH,
    parameter int RFIDX_W = CORE_RFIDX_WIDTH,
    parameter int PTR_W   = $clog2(CORE_SB_DEPTH),
    parameter int CNT_W   = $clog2(CORE_SB_DEPTH + 1)
) (
    input  logic [DEPTH-1:0]         wen,
    input  logic [DEPTH-1:0]         done,
    input  logic [DEPTH*RFIDX_W-1:0] rd_idx,
    input  logic [PTR_W-1:0]         head,
    input  logic [CNT_W-1:0]         cnt,
    input  logic                     ren,
    input  logic [RFIDX_W-1:0]       idx,
    output logic                     hit,
    output logic                     hit_done
);
    // Walk oldest to youngest so the last match seen is the youngest producer.
    always_comb begin
        logic [PTR_W-1:0] e;
        hit      = 1'b0;
        hit_done = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            e = head + PTR_W'(k);
            if (ren && idx != '0 && k < int'(cnt) && wen[e] && rd_idx[e*RFIDX_W +: RFIDX_W] == idx) begin
                hit      = 1'b1;
                hit_done = done[e];
            end
        end
    end
endmodule

// File: rtl/core_id_scoreboard.sv
// core_id_scoreboard: in-order in-flight rd tracker raising RAW stalls for decode, with flush support.
module core_id_scoreboard
    import core_id_scoreboard_pkg::*;
#(
    parameter int DEPTH   = CORE_SB_DEPTH,
    parameter int RFIDX_W = CORE_RFIDX_WIDTH,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_issue_valid,
    output logic               o_issue_ready,
    input  logic               i_issue_rd_wen,
    input  logic [RFIDX_W-1:0] i_issue_rd_idx,
    input  logic               i_rs1_ren,
    input  logic               i_rs2_ren,
    input  logic [RFIDX_W-1:0] i_rs1_idx,
    input  logic [RFIDX_W-1:0] i_rs2_idx,
    input  logic               i_ex_done,
    input  logic               i_wb_valid,
    input  logic               i_pipe_flush_req,
    input  logic [CNT_W-1:0]   i_flush_keep,
    output logic               o_raw_stall,
    output logic [CNT_W-1:0]   o_cnt,
    output logic               o_empty,
    output logic               o_full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]         head, tail, head_nxt, tail_nxt, ex_ptr;
    logic [CNT_W-1:0]         cnt, cnt_nxt, ex_age;
    logic [DEPTH-1:0]         wen, done;
    logic [DEPTH*RFIDX_W-1:0] rd;
    logic                     issue_fire, retire, ex_found, ex_fire;
    logic                     rs1_hit, rs1_done, rs2_hit, rs2_done;

    assign o_cnt         = cnt;
    assign o_empty       = cnt == '0;
    assign o_full        = cnt == CNT_W'(DEPTH);
    assign o_issue_ready = ~o_full;
    assign issue_fire    = i_issue_valid & ~o_full & ~i_pipe_flush_req;
    assign retire        = i_wb_valid & ~o_empty;

    // Results complete in order, so the first not-done entry from the head is the ex_done target.
    always_comb begin
        logic [PTR_W-1:0] e;
        ex_found = 1'b0;
        ex_ptr   = '0;
        ex_age   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            e = head + PTR_W'(k);
            if (!ex_found && k < int'(cnt) && !done[e]) begin
                ex_found = 1'b1;
                ex_ptr   = e;
                ex_age   = CNT_W'(k);
            end
        end
    end

    assign ex_fire  = i_ex_done & ex_found & (~i_pipe_flush_req | (ex_age < i_flush_keep));
    assign head_nxt = head + PTR_W'(retire);
    assign tail_nxt = i_pipe_flush_req ? head + i_flush_keep[PTR_W-1:0] : tail + PTR_W'(issue_fire);
    assign cnt_nxt  = i_pipe_flush_req ? i_flush_keep - CNT_W'(retire)
                                       : cnt + CNT_W'(issue_fire) - CNT_W'(retire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            wen  <= '0;
            done <= '0;
            rd   <= '0;
        end else begin
            head <= head_nxt;
            tail <= tail_nxt;
            cnt  <= cnt_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire && tail == PTR_W'(i)) begin
                    wen[i]                   <= i_issue_rd_wen & (i_issue_rd_idx != '0);
                    rd[i*RFIDX_W +: RFIDX_W] <= i_issue_rd_idx;
                    done[i]                  <= 1'b0;
                end else if (ex_fire && ex_ptr == PTR_W'(i)) begin
                    done[i] <= 1'b1;
                end
            end
        end
    end

    core_sb_match #(.DEPTH(DEPTH), .RFIDX_W(RFIDX_W), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_rs1 (
        .wen(wen), .done(done), .rd_idx(rd), .head(head), .cnt(cnt),
        .ren(i_rs1_ren), .idx(i_rs1_idx), .hit(rs1_hit), .hit_done(rs1_done)
    );

    core_sb_match #(.DEPTH(DEPTH), .RFIDX_W(RFIDX_W), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_rs2 (
        .wen(wen), .done(done), .rd_idx(rd), .head(head), .cnt(cnt),
        .ren(i_rs2_ren), .idx(i_rs2_idx), .hit(rs2_hit), .hit_done(rs2_done)
    );

    assign o_raw_stall = (rs1_hit & ~rs1_done) | (rs2_hit & ~rs2_done);

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_wb_valid && o_empty)) else $error("retire while empty");
            assert (!i_pipe_flush_req || (i_flush_keep <= cnt && i_flush_keep >= CNT_W'(i_wb_valid)))
                else $error("flush keep out of range");
        end
    end
endmodule

// File: tb/tb_core_id_scoreboard.sv
// tb_core_id_scoreboard: directed checks of issue/stall/ex_done/retire/flush/reset behaviour.
module tb_core_id_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_ready, issue_rd_wen;
    logic [4:0] issue_rd_idx, rs1_idx, rs2_idx;
    logic       rs1_ren, rs2_ren, ex_done, wb_valid, flush_req;
    logic [2:0] flush_keep, cnt;
    logic       raw_stall, empty, full;
    int         checks = 0;
    int         errors = 0;

    core_id_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
        .i_issue_rd_wen(issue_rd_wen), .i_issue_rd_idx(issue_rd_idx),
        .i_rs1_ren(rs1_ren), .i_rs2_ren(rs2_ren), .i_rs1_idx(rs1_idx), .i_rs2_idx(rs2_idx),
        .i_ex_done(ex_done), .i_wb_valid(wb_valid),
        .i_pipe_flush_req(flush_req), .i_flush_keep(flush_keep),
        .o_raw_stall(raw_stall), .o_cnt(cnt), .o_empty(empty), .o_full(full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1; issue_rd_wen = 1'b1; issue_rd_idx = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic pulse_ex();
        ex_done = 1'b1; tick(); ex_done = 1'b0;
    endtask

    task automatic pulse_wb();
        wb_valid = 1'b1; tick(); wb_valid = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] idx);
        rs1_ren = 1'b1; rs1_idx = idx; #1;
    endtask

    task automatic rd2(input logic [4:0] idx);
        rs2_ren = 1'b1; rs2_idx = idx; #1;
    endtask

    initial begin
        rst_n = 1'b0; issue_valid = 0; issue_rd_wen = 0; issue_rd_idx = 0;
        rs1_ren = 0; rs2_ren = 0; rs1_idx = 0; rs2_idx = 0;
        ex_done = 0; wb_valid = 0; flush_req = 0; flush_keep = 0;
        #12;
        chk("rst_cnt", cnt, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_stall", raw_stall, 0);
        rst_n = 1'b1;
        tick();

        issue(5);
        rd1(5);
        chk("rd5_stall", raw_stall, 1);
        chk("rd5_cnt", cnt, 1);
        pulse_ex();
        chk("rd5_done_nostall", raw_stall, 0);
        pulse_wb();
        chk("rd5_ret_cnt", cnt, 0);
        chk("rd5_ret_empty", empty, 1);

        issue(0);
        rd1(0);
        chk("rd0_nostall", raw_stall, 0);
        chk("rd0_cnt", cnt, 1);
        pulse_wb();
        rs1_ren = 0;

        issue(7);
        issue(7);
        pulse_ex();
        rd2(7);
        chk("rd7_young_stall", raw_stall, 1);
        pulse_ex();
        chk("rd7_all_done", raw_stall, 0);
        pulse_wb();
        pulse_wb();
        chk("rd7_empty", empty, 1);
        rs2_ren = 0;

        for (int i = 0; i < 4; i++) issue(5'(10 + i));
        chk("full_flag", full, 1);
        chk("full_ready", issue_ready, 0);
        chk("full_cnt", cnt, 4);
        issue_valid = 1; issue_rd_idx = 30; wb_valid = 1;
        tick();
        chk("full_pair_cnt", cnt, 3);
        chk("full_pair_ready", issue_ready, 1);
        for (int j = 0; j < 8; j++) begin
            issue_rd_idx = 5'(20 + j);
            tick();
            chk("wrap_cnt", cnt, 3);
        end
        issue_valid = 0; wb_valid = 0;
        rd1(27);
        chk("wrap_rd27_stall", raw_stall, 1);
        rd1(30);
        chk("wrap_rd30_dropped", raw_stall, 0);
        rd1(24);
        chk("wrap_rd24_retired", raw_stall, 0);
        rd2(25);
        chk("wrap_rd25_stall", raw_stall, 1);
        rs2_ren = 0;
        pulse_wb(); pulse_wb(); pulse_wb();
        chk("wrap_empty", empty, 1);

        issue(1); issue(2); issue(3);
        flush_req = 1; flush_keep = 1;
        issue_valid = 1; issue_rd_idx = 9;
        tick();
        flush_req = 0; issue_valid = 0;
        chk("flush_cnt", cnt, 1);
        rd1(3);
        chk("flush_rd3", raw_stall, 0);
        rd1(9);
        chk("flush_rd9_dropped", raw_stall, 0);
        rd1(1);
        chk("flush_rd1", raw_stall, 1);
        issue(2);
        flush_req = 1; flush_keep = 1; wb_valid = 1;
        tick();
        flush_req = 0; wb_valid = 0;
        chk("flush_wb_cnt", cnt, 0);
        chk("flush_wb_stall", raw_stall, 0);

        issue(4); issue(5);
        flush_req = 1; flush_keep = 1; ex_done = 1;
        tick();
        flush_req = 0; ex_done = 0;
        chk("flush_ex_cnt", cnt, 1);
        rd1(4);
        chk("flush_ex_kept_done", raw_stall, 0);
        rd1(5);
        chk("flush_ex_rd5_gone", raw_stall, 0);
        pulse_wb();

        issue(1); issue(2); issue(3);
        rd1(3);
        chk("pre_rst_stall", raw_stall, 1);
        rst_n = 0;
        #1;
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_stall", raw_stall, 0);
        chk("async_rst_empty", empty, 1);
        #2;
        rst_n = 1;
        tick();
        issue(14);
        rd1(14);
        chk("post_rst_stall", raw_stall, 1);
        chk("post_rst_cnt", cnt, 1);
        rd1(3);
        chk("post_rst_old_gone", raw_stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
